// File: rtl/vproc_pkg.sv
// Shared constants, types and helpers for the vector divider issue path.
package vproc_pkg;

  localparam logic [31:0] DIV_INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_SPC_NONE,
    DIV_SPC_ZERO,
    DIV_SPC_OVFL
  } div_special_e;

  function automatic div_special_e div_classify(input logic [31:0] op1, input logic [31:0] op2);
    if (op2 == '0)                                  return DIV_SPC_ZERO;
    else if (op1 == DIV_INT_MIN && op2 == DIV_ALL_ONES) return DIV_SPC_OVFL;
    else                                            return DIV_SPC_NONE;
  endfunction

  // RISC-V results for the cases the datapath is never asked to compute
  function automatic logic [31:0] div_fix_result(input div_special_e spc, input logic mod,
                                                 input logic [31:0] op1, input logic [31:0] res);
    case (spc)
      DIV_SPC_ZERO: return mod ? op1 : DIV_ALL_ONES;
      DIV_SPC_OVFL: return mod ? '0 : DIV_INT_MIN;
      default:      return res;
    endcase
  endfunction

endpackage

// File: rtl/vproc_div_res_fifo.sv
// Generic circular FIFO; simultaneous push/pop is honoured even when full.
module vproc_div_res_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              async_rst_i,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              pop_ok;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign pop_ok = pop & ~empty;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (push & ~pop_ok)      cnt <= cnt + 1'b1;
      else if (~push & pop_ok) cnt <= cnt - 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (async_rst_i) !(push && full && !pop));

endmodule

// File: rtl/vproc_div_ctrl.sv
// Issue controller for the fixed-latency divider: corner-case override and
// credit-protected result buffering so the datapath never has to stall.
import vproc_pkg::*;

module vproc_div_ctrl #(
  parameter int unsigned DIV_LAT = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             async_rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_op1_i,
  input  logic [31:0]      in_op2_i,
  input  logic             in_mod_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic [31:0]      div_op1_o,
  output logic [31:0]      div_op2_o,
  output logic             div_mod_o,
  input  logic [31:0]      div_res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_res_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);

  localparam int unsigned FIFO_DEPTH = DIV_LAT + 2;
  localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FIFO_W     = TAG_W + 32;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             mod;
    div_special_e     spc;
    logic [31:0]      op1;
  } div_side_t;

  logic             accept, pop;
  logic [OCC_W-1:0] occ_q;
  div_special_e     spc_in;
  div_side_t        side_in, side_exit;
  logic [31:0]      res_exit;
  logic             fifo_full, fifo_empty;

  // Credits cover both in-flight ops and buffered results, so every op
  // leaving the datapath is guaranteed a FIFO slot.
  assign in_ready_o = (occ_q < OCC_W'(FIFO_DEPTH));
  assign accept     = in_valid_i & in_ready_o;
  assign pop        = out_valid_o & out_ready_i;
  assign busy_o     = (occ_q != '0);

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i)            occ_q <= '0;
    else if (accept & ~pop)     occ_q <= occ_q + 1'b1;
    else if (~accept & pop)     occ_q <= occ_q - 1'b1;
  end

  assign spc_in    = div_classify(in_op1_i, in_op2_i);
  assign div_op1_o = in_op1_i;
  assign div_mod_o = in_mod_i;
  // Special cases get a harmless divisor; their result is replaced at exit
  assign div_op2_o = (spc_in == DIV_SPC_NONE) ? in_op2_i : 32'd1;

  assign side_in = '{valid: accept, tag: in_tag_i, mod: in_mod_i, spc: spc_in, op1: in_op1_i};

  if (DIV_LAT == 0) begin : g_nolat
    assign side_exit = side_in;
  end else begin : g_lat
    div_side_t side_q [DIV_LAT];

    always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
        for (int i = 0; i < DIV_LAT; i++) side_q[i] <= '0;
      end else begin
        side_q[0] <= side_in;
        for (int i = 1; i < DIV_LAT; i++) side_q[i] <= side_q[i-1];
      end
    end

    assign side_exit = side_q[DIV_LAT-1];
  end

  assign res_exit = div_fix_result(side_exit.spc, side_exit.mod, side_exit.op1, div_res_i);

  vproc_div_res_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_res_fifo (
    .clk_i       (clk_i),
    .async_rst_i (async_rst_i),
    .push        (side_exit.valid),
    .wdata       ({side_exit.tag, res_exit}),
    .pop         (pop),
    .rdata       ({out_tag_o, out_res_o}),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign out_valid_o = ~fifo_empty;

  a_credit_slot: assert property (@(posedge clk_i) disable iff (async_rst_i)
                                  !(side_exit.valid && fifo_full && !pop));

endmodule

// File: tb/tb_vproc_div_ctrl.sv
// Randomized and directed bench for vproc_div_ctrl with an emulated 2-stage datapath.
module tb_vproc_div_ctrl;

  localparam int DIV_LAT = 2;
  localparam int TAG_W   = 4;
  localparam int DEPTH   = DIV_LAT + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_mod;
  logic [31:0]      in_op1, in_op2;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      div_op1, div_op2, div_res;
  logic             div_mod;
  logic             out_valid, out_ready, busy;
  logic [31:0]      out_res;
  logic [TAG_W-1:0] out_tag;

  int vec = 0;
  int err = 0;
  logic [31:0]      exp_res [$];
  logic [TAG_W-1:0] exp_tag [$];

  always #5 clk = ~clk;

  vproc_div_ctrl #(.DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .async_rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op1_i(in_op1), .in_op2_i(in_op2),
    .in_mod_i(in_mod), .in_tag_i(in_tag),
    .div_op1_o(div_op1), .div_op2_o(div_op2), .div_mod_o(div_mod), .div_res_i(div_res),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_res_o(out_res), .out_tag_o(out_tag),
    .busy_o(busy)
  );

  // RISC-V signed divide semantics
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic m);
    if (b == 0) return m ? a : 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'h0 : 32'h8000_0000;
    return m ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  // Emulated datapath: garbage on operands it must never see
  function automatic logic [31:0] dp_f(input logic [31:0] a, input logic [31:0] b, input logic m);
    if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 32'hDEAD_BEEF;
    return m ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  logic [31:0] dp_q [DIV_LAT];
  always @(posedge clk) begin
    dp_q[0] <= dp_f(div_op1, div_op2, div_mod);
    for (int i = 1; i < DIV_LAT; i++) dp_q[i] <= dp_q[i-1];
  end
  assign div_res = dp_q[DIV_LAT-1];

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic m, input logic [TAG_W-1:0] t);
    in_valid = v; in_op1 = a; in_op2 = b; in_mod = m; in_tag = t;
    #1;
  endtask

  task automatic step(output logic acc, output logic pop,
                      output logic [31:0] r, output logic [TAG_W-1:0] t);
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    r = out_res; t = out_tag;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec++; if (busy !== 1'b0)      begin err++; $display("FAIL reset_busy got %b want 0", busy); end
    vec++; if (in_ready !== 1'b1)  begin err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic acc, pop; logic [31:0] r; logic [TAG_W-1:0] t;
    out_ready = 1'b1;
    drive(1, 100, 7, 0, 3);
    step(acc, pop, r, t);
    vec++; if (acc !== 1'b1) begin err++; $display("FAIL basic_accept got %b want 1", acc); end
    drive(0, 0, 0, 0, 0);
    for (int c = 1; c <= DIV_LAT + 1; c++) begin
      vec++;
      if (out_valid !== (c == DIV_LAT + 1)) begin
        err++; $display("FAIL basic_latency cycle %0d got %b want %b", c, out_valid, c == DIV_LAT + 1);
      end
      step(acc, pop, r, t);
    end
    vec++; if (r !== 32'd14) begin err++; $display("FAIL basic_res got %0d want 14", r); end
    vec++; if (t !== 4'd3)   begin err++; $display("FAIL basic_tag got %0d want 3", t); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL basic_busy_idle got %b want 0", busy); end
  endtask

  task automatic test_corner;
    logic [31:0] a [6] = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd55, 32'd55, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [6] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic        m [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] e [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'd55, 32'h8000_0000, 32'd0};
    logic [31:0] op2_exp;
    logic acc, pop; logic [31:0] r; logic [TAG_W-1:0] t;
    int ni = 0, no = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && no < 6; c++) begin
      if (ni < 6) begin
        drive(1, a[ni], b[ni], m[ni], TAG_W'(ni));
        op2_exp = (ni >= 2) ? 32'd1 : 32'd7;
        vec++;
        if (div_op2 !== op2_exp) begin err++; $display("FAIL corner_div_op2 op %0d got %h want %h", ni, div_op2, op2_exp); end
      end else drive(0, 0, 0, 0, 0);
      step(acc, pop, r, t);
      if (acc) ni++;
      if (pop) begin
        vec++;
        if (r !== e[no] || t !== TAG_W'(no)) begin
          err++; $display("FAIL corner_res op %0d got %h/tag %0d want %h/tag %0d", no, r, t, e[no], no);
        end
        no++;
      end
    end
    vec++; if (no != 6) begin err++; $display("FAIL corner_count got %0d want 6", no); end
  endtask

  task automatic test_backpressure;
    logic acc, pop; logic [31:0] r; logic [TAG_W-1:0] t;
    logic [31:0] a, b; logic md;
    int n = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a = $urandom; b = $urandom; md = 1'($urandom_range(0, 1));
      drive(1, a, b, md, TAG_W'(c));
      step(acc, pop, r, t);
      if (acc) begin exp_res.push_back(ref_div(a, b, md)); exp_tag.push_back(TAG_W'(c)); n++; end
    end
    drive(0, 0, 0, 0, 0);
    vec++; if (n != DEPTH) begin err++; $display("FAIL bp_accept_count got %0d want %0d", n, DEPTH); end
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
    out_ready = 1'b1; #1;
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL bp_ready_pop_cycle got %b want 0", in_ready); end
    for (int c = 0; c < 20 && exp_res.size() > 0; c++) begin
      step(acc, pop, r, t);
      if (c == 0) begin
        vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL bp_ready_after_pop got %b want 1", in_ready); end
      end
      if (pop) begin
        vec++;
        if (r !== exp_res[0] || t !== exp_tag[0]) begin
          err++; $display("FAIL bp_order got %h/tag %0d want %h/tag %0d", r, t, exp_res[0], exp_tag[0]);
        end
        void'(exp_res.pop_front()); void'(exp_tag.pop_front());
      end
    end
    vec++; if (exp_res.size() != 0) begin err++; $display("FAIL bp_drain left %0d want 0", exp_res.size()); end
  endtask

  task automatic test_random;
    logic acc, pop; logic [31:0] r; logic [TAG_W-1:0] t;
    logic [31:0] a, b; logic md; int sel; int occ = 0;
    for (int c = 0; c < 430; c++) begin
      sel = $urandom_range(0, 19);
      a = $urandom; b = $urandom; md = 1'($urandom_range(0, 1));
      if (sel < 2) b = 0;
      else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 6) b = $urandom_range(1, 9);
      drive((c < 400) && ($urandom_range(0, 9) < 7), a, b, md, TAG_W'($urandom));
      out_ready = (c >= 400) || ($urandom_range(0, 9) < 6);
      #1;
      vec++;
      if (in_ready !== (occ < DEPTH) || busy !== (occ != 0)) begin
        err++; $display("FAIL rand_credit cycle %0d ready %b busy %b want %b %b", c, in_ready, busy, occ < DEPTH, occ != 0);
      end
      step(acc, pop, r, t);
      if (acc) begin exp_res.push_back(ref_div(a, b, md)); exp_tag.push_back(in_tag); occ++; end
      if (pop) begin
        vec++;
        if (exp_res.size() == 0) begin
          err++; $display("FAIL rand_spurious cycle %0d got %h want none", c, r);
        end else begin
          if (r !== exp_res[0] || t !== exp_tag[0]) begin
            err++; $display("FAIL rand_res cycle %0d got %h/tag %0d want %h/tag %0d", c, r, t, exp_res[0], exp_tag[0]);
          end
          void'(exp_res.pop_front()); void'(exp_tag.pop_front());
        end
        occ--;
      end
    end
    vec++; if (exp_res.size() != 0 || busy !== 1'b0) begin
      err++; $display("FAIL rand_drain left %0d busy %b want 0 0", exp_res.size(), busy);
    end
  endtask

  task automatic test_reset_midflight;
    logic acc, pop; logic [31:0] r; logic [TAG_W-1:0] t;
    logic stale = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom_range(1, 100), 0, TAG_W'(i + 5));
      step(acc, pop, r, t);
    end
    drive(0, 0, 0, 0, 0);
    vec++; if (busy !== 1'b1) begin err++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
    rst = 1'b1; #1;
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
    vec++; if (busy !== 1'b0)      begin err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    #1 rst = 1'b0;
    exp_res.delete(); exp_tag.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      step(acc, pop, r, t);
    end
    vec++; if (stale) begin err++; $display("FAIL rst_mid_stale got 1 want 0"); end
    drive(1, 32'hFFFF_FFF9, 32'd2, 0, 4'd9);
    step(acc, pop, r, t);
    drive(0, 0, 0, 0, 0);
    repeat (DIV_LAT) step(acc, pop, r, t);
    vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL rst_mid_relatency got %b want 1", out_valid); end
    vec++; if (out_res !== 32'hFFFF_FFFD || out_tag !== 4'd9) begin
      err++; $display("FAIL rst_mid_res got %h/tag %0d want fffffffd/tag 9", out_res, out_tag);
    end
    step(acc, pop, r, t);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corner;
    test_backpressure;
    test_random;
    test_reset_midflight;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/vproc_div_ctrl.md
Name: vproc_div_ctrl

Overview:
- Issue controller for the fixed-latency signed 32-bit divider datapath (quotient/remainder, non-stallable pipeline of DIV_LAT stages).
- Accepts element-wise divide requests over a valid/ready handshake and forwards them to the datapath.
- Applies RISC-V corner-case semantics for divide-by-zero and overflow.
- Absorbs datapath results in a credit-protected output FIFO so downstream backpressure never stalls the divider.

Parameters:
- DIV_LAT, 2, datapath latency in cycles; legal 0..3; must match the number of buffer stages enabled in the datapath.
- TAG_W, 4, width of the request tag carried alongside each operation.
- FIFO_DEPTH, DIV_LAT+2, output FIFO entries; derived, not overridden.

Ports:
- clk_i  in  1  clock
- async_rst_i  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o
- in_op1_i  in  32  dividend (signed)
- in_op2_i  in  32  divisor (signed)
- in_mod_i  in  1  0 = quotient, 1 = remainder
- in_tag_i  in  TAG_W  request tag
- div_op1_o  out  32  datapath dividend
- div_op2_o  out  32  datapath divisor
- div_mod_o  out  1  datapath mode
- div_res_i  in  32  datapath result, valid DIV_LAT cycles after issue
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when out_valid_o && out_ready_i
- out_res_o  out  32  final result
- out_tag_o  out  TAG_W  tag of the result
- busy_o  out  1  any operation in flight or buffered

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (async_rst_i).
- Reset state:
  - Pipeline valid bits, FIFO pointers and occupancy counter cleared.
  - out_valid_o = 0, busy_o = 0, in_ready_o = 1.
  - div_*_o are don't-care.
- Reset mid-operation: all in-flight and buffered results are dropped; no output is produced for them.
- Occupancy counter: occ = in-flight datapath ops + FIFO entries, range 0..FIFO_DEPTH.
  - Accept: +1. Output pop: -1. Both in the same cycle: unchanged.
- Ready logic: in_ready_o = (occ < FIFO_DEPTH). It is driven from registers only, with no combinational path from out_ready_i. A slot freed by a pop becomes visible the next cycle.
- Issue: on accept, drive div_op1_o = in_op1_i and div_mod_o = in_mod_i combinationally in the same cycle. div_op2_o = in_op2_i, except for special cases, where it is forced to 1 to keep the datapath X-free.
- Special-case detection at issue:
  - Divide-by-zero: op2 == 0.
  - Overflow: op1 == 32'h8000_0000 && op2 == 32'hFFFF_FFFF.
- Sideband shift register, DIV_LAT stages of {valid, tag, mod, special_kind, op1}. It advances every cycle unconditionally.
- Result override at pipeline exit:
  - Divide-by-zero: quotient = 32'hFFFF_FFFF; remainder = op1.
  - Overflow: quotient = 32'h8000_0000; remainder = 0.
  - Otherwise: div_res_i.
- FIFO write: the exit-stage result and tag are written into the FIFO at the end of cycle t+DIV_LAT, where t is the accept cycle. For DIV_LAT = 0, div_res_i is sampled in the accept cycle itself.
- Latency: out_valid_o rises at cycle t+DIV_LAT+1 when the FIFO was empty; results leave in strict acceptance order.
- FIFO behaviour:
  - Circular, with pointer wrap at FIFO_DEPTH.
  - Write and read in the same cycle are both honoured, including at full: the credit scheme guarantees a slot.
  - A write into a full FIFO cannot occur; the implementation asserts this in simulation.
- busy_o = (occ != 0).
- Throughput: 1 op/cycle while out_ready_i stays high.

Decomposition:
- vproc_pkg additions:
  - DIV_INT_MIN = 32'h8000_0000 and DIV_ALL_ONES constants.
  - div_special_e enum {DIV_SPC_NONE, DIV_SPC_ZERO, DIV_SPC_OVFL}.
  - div_side_t struct {valid, tag, mod, spc, op1}; the tag is kept as a parameterized field width in the instantiating module.
- One sub-module: vproc_div_res_fifo, a generic synchronous FIFO with data width and depth parameters and push/pop/full/empty ports.
- The occupancy counter and special-case logic stay in vproc_div_ctrl.

Test Plan:
- Basic quotient: DIV_LAT = 2, request op1 = 100, op2 = 7, mod = 0, tag = 3 accepted at cycle 0 -> out_valid_o at cycle 3, out_res_o = 14, out_tag_o = 3.
- Negative remainder: request op1 = -100, op2 = 7, mod = 1 -> out_res_o = -2 (32'hFFFF_FFFE); same op1/op2 with mod = 0 -> -14.
- Divide-by-zero: request op1 = 55, op2 = 0 -> div_op2_o = 1 at issue; mod = 0 gives 32'hFFFF_FFFF, mod = 1 gives 55.
- Overflow: request op1 = 32'h8000_0000, op2 = -1 -> mod = 0 gives 32'h8000_0000, mod = 1 gives 0.
- Backpressure:
  - Hold out_ready_i = 0 and stream requests -> exactly FIFO_DEPTH = 4 accepted, then in_ready_o = 0.
  - Raise out_ready_i -> in_ready_o returns 1 one cycle after the first pop; all tags appear in order with no loss or duplication.
- Reset mid-flight: with 3 ops in flight, pulse async_rst_i asynchronously -> out_valid_o = 0 and busy_o = 0 immediately; no stale result appears after release; a new request completes normally at latency DIV_LAT+1.
